// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle for the pipelined FP multiplier
interface fp_mul_pipe_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_rnd;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p;
  logic [3:0]   out_flags;

  // Producer of operands and consumer of products (operand fetch / MAC side)
  modport master (
    output in_valid, in_a, in_b, in_rnd, out_ready,
    input  in_ready, out_valid, out_p, out_flags
  );

  // The multiplier itself
  modport slave (
    input  in_valid, in_a, in_b, in_rnd, out_ready,
    output in_ready, out_valid, out_p, out_flags
  );
endinterface

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - 3-stage pipelined FP multiplier, RNE/RTZ, FTZ, exception flags
module fp_mul_pipe #(
  parameter int EXP_W = 4,
  parameter int MAN_W = 3,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_mul_pipe_if.slave  bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2*MAN_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX = EW'(2**EXP_W - 1);

  // Whole pipe advances together; a stalled output freezes every stage.
  logic en;
  assign en            = !bus.out_valid || bus.out_ready;
  assign bus.in_ready  = en;

  // Stage 1 state
  logic                 v1_q, v1_d;
  logic                 sign1_q, sign1_d;
  logic signed [EW-1:0] exp1_q, exp1_d;
  logic [PW-1:0]        prod1_q, prod1_d;
  logic                 nan1_q, nan1_d, inf1_q, inf1_d, zero1_q, zero1_d;
  logic                 rnd1_q, rnd1_d;
  // Stage 2 state
  logic                 v2_q, v2_d;
  logic                 sign2_q, sign2_d;
  logic signed [EW-1:0] exp2_q, exp2_d;
  logic [MAN_W-1:0]     man2_q, man2_d;
  logic                 inexact2_q, inexact2_d;
  logic                 nan2_q, nan2_d, inf2_q, inf2_d, zero2_q, zero2_d;
  logic                 rnd2_q, rnd2_d;
  // Stage 3 (output register)
  logic                 out_valid_q, out_valid_d;
  logic [W-1:0]         p_q, p_d;
  logic [3:0]           flags_q, flags_d;

  assign bus.out_valid = out_valid_q;
  assign bus.out_p     = p_q;
  assign bus.out_flags = flags_q;

  // Stage 1: unpack, classify, sign, biased exponent sum and significand product
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [PW-1:0]    sig_a, sig_b;
  always_comb begin
    a_exp   = bus.in_a[W-2:MAN_W];
    b_exp   = bus.in_b[W-2:MAN_W];
    a_man   = bus.in_a[MAN_W-1:0];
    b_man   = bus.in_b[MAN_W-1:0];
    a_zero  = (a_exp == '0);
    b_zero  = (b_exp == '0);
    a_inf   = (&a_exp) && (a_man == '0);
    b_inf   = (&b_exp) && (b_man == '0);
    a_nan   = (&a_exp) && (a_man != '0);
    b_nan   = (&b_exp) && (b_man != '0);
    sig_a   = PW'({1'b1, a_man});
    sig_b   = PW'({1'b1, b_man});
    v1_d    = bus.in_valid;
    sign1_d = bus.in_a[W-1] ^ bus.in_b[W-1];
    exp1_d  = EW'({2'b00, a_exp}) + EW'({2'b00, b_exp}) - EW'(BIAS);
    prod1_d = sig_a * sig_b;
    nan1_d  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    inf1_d  = a_inf || b_inf;
    zero1_d = a_zero || b_zero;
    rnd1_d  = bus.in_rnd;
  end

  // Stage 2: normalise product into [1,2), extract guard/sticky, round
  logic [MAN_W-1:0]     man_t;
  logic                 guard, sticky, inc;
  logic signed [EW-1:0] exp_n;
  logic [MAN_W:0]       man_sum;
  always_comb begin
    if (prod1_q[PW-1]) begin
      man_t  = prod1_q[PW-2 -: MAN_W];
      guard  = prod1_q[MAN_W];
      sticky = |prod1_q[MAN_W-1:0];
      exp_n  = exp1_q + EW'(1);
    end else begin
      man_t  = prod1_q[PW-3 -: MAN_W];
      guard  = prod1_q[MAN_W-1];
      sticky = |prod1_q[MAN_W-2:0];
      exp_n  = exp1_q;
    end
    inc     = !rnd1_q && guard && (sticky || man_t[0]);
    man_sum = {1'b0, man_t} + (MAN_W+1)'(inc);
    if (man_sum[MAN_W]) begin
      man2_d = '0;
      exp2_d = exp_n + EW'(1);
    end else begin
      man2_d = man_sum[MAN_W-1:0];
      exp2_d = exp_n;
    end
    v2_d       = v1_q;
    sign2_d    = sign1_q;
    inexact2_d = guard || sticky;
    nan2_d     = nan1_q;
    inf2_d     = inf1_q;
    zero2_d    = zero1_q;
    rnd2_d     = rnd1_q;
  end

  // Stage 3: specials by priority, then overflow/underflow, then pack
  always_comb begin
    out_valid_d = v2_q;
    p_d         = {sign2_q, exp2_q[EXP_W-1:0], man2_q};
    flags_d     = {3'b000, inexact2_q};
    if (nan2_q) begin
      p_d     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flags_d = 4'b1000;
    end else if (inf2_q) begin
      p_d     = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0000;
    end else if (zero2_q) begin
      p_d     = {sign2_q, {(W-1){1'b0}}};
      flags_d = 4'b0000;
    end else if (exp2_q >= EXP_MAX) begin
      p_d     = rnd2_q ? {sign2_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                       : {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (exp2_q[EW-1] || (exp2_q == '0)) begin
      p_d     = {sign2_q, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end
  end

  // Pipeline registers: cleared by reset, frozen while the output is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0; sign1_q <= 1'b0; exp1_q <= '0; prod1_q <= '0;
      nan1_q <= 1'b0; inf1_q <= 1'b0; zero1_q <= 1'b0; rnd1_q <= 1'b0;
      v2_q <= 1'b0; sign2_q <= 1'b0; exp2_q <= '0; man2_q <= '0; inexact2_q <= 1'b0;
      nan2_q <= 1'b0; inf2_q <= 1'b0; zero2_q <= 1'b0; rnd2_q <= 1'b0;
      out_valid_q <= 1'b0; p_q <= '0; flags_q <= '0;
    end else if (en) begin
      v1_q <= v1_d; sign1_q <= sign1_d; exp1_q <= exp1_d; prod1_q <= prod1_d;
      nan1_q <= nan1_d; inf1_q <= inf1_d; zero1_q <= zero1_d; rnd1_q <= rnd1_d;
      v2_q <= v2_d; sign2_q <= sign2_d; exp2_q <= exp2_d; man2_q <= man2_d; inexact2_q <= inexact2_d;
      nan2_q <= nan2_d; inf2_q <= inf2_d; zero2_q <= zero2_d; rnd2_q <= rnd2_d;
      out_valid_q <= out_valid_d; p_q <= p_d; flags_q <= flags_d;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb/tb_fp_mul_pipe.sv - directed self-checking bench for fp_mul_pipe (E4M3)
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_mul_pipe_if #(.W(8)) bus ();

  fp_mul_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-computed E4M3 vectors
  logic [7:0] a_v [8];
  logic [7:0] b_v [8];
  logic       r_v [8];
  logic [7:0] p_v [8];
  logic [3:0] f_v [8];

  int         sent, rx, cyc, extra;
  logic       held, fire_in, fire_out;
  logic [7:0] held_p;

  initial begin
    a_v = '{8'h3C, 8'h3C, 8'h3C, 8'h77, 8'h77, 8'h78, 8'h08, 8'hB8};
    b_v = '{8'h3C, 8'h39, 8'h39, 8'h77, 8'h77, 8'h00, 8'h08, 8'h38};
    r_v = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0};
    p_v = '{8'h41, 8'h3E, 8'h3D, 8'h78, 8'h77, 8'h7C, 8'h00, 8'hB8};
    f_v = '{4'h0,  4'h1,  4'h1,  4'h5,  4'h5,  4'h8,  4'h3,  4'h0};

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_rnd = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_p", 32'(bus.out_p), 32'h00);
    check("rst_out_flags", 32'(bus.out_flags), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Isolated operations: latency and result per vector
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a = a_v[i]; bus.in_b = b_v[i]; bus.in_rnd = r_v[i];
      #1;
      check($sformatf("single%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check($sformatf("single%0d_lat1", i), 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("single%0d_lat2", i), 32'(bus.out_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("single%0d_lat3", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("single%0d_p", i), 32'(bus.out_p), 32'(p_v[i]));
      check($sformatf("single%0d_flags", i), 32'(bus.out_flags), 32'(f_v[i]));
      @(posedge clk); #1;
      check($sformatf("single%0d_drained", i), 32'(bus.out_valid), 32'd0);
    end

    // Back-to-back stream with out_ready pattern 1,0,0,1,0,0,...
    sent = 0; rx = 0; cyc = 0; held = 1'b0; held_p = '0;
    while (rx < 8 && cyc < 80) begin
      @(negedge clk);
      bus.out_ready = (cyc % 3 == 0);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.in_a = a_v[sent]; bus.in_b = b_v[sent]; bus.in_rnd = r_v[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (held) begin
        check("stall_valid_hold", 32'(bus.out_valid), 32'd1);
        check("stall_p_hold", 32'(bus.out_p), 32'(held_p));
      end
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        check($sformatf("stream%0d_p", rx), 32'(bus.out_p), 32'(p_v[rx]));
        check($sformatf("stream%0d_flags", rx), 32'(bus.out_flags), 32'(f_v[rx]));
      end
      held   = bus.out_valid && !bus.out_ready;
      held_p = bus.out_p;
      @(posedge clk);
      if (fire_in) sent++;
      if (fire_out) rx++;
      cyc++;
    end
    check("stream_count", 32'(rx), 32'd8);
    extra = 0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.out_valid) extra++;
    end
    check("stream_no_dup", 32'(extra), 32'd0);

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_a = a_v[i]; bus.in_b = b_v[i]; bus.in_rnd = r_v[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_out_p", 32'(bus.out_p), 32'h00);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) extra++;
    end
    check("midrst_no_ghost", 32'(extra), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
